// File: rtl/answer_history.sv
// Circular history of captured answers with edge-detected store/prev/next
// buttons; presents the selected entry as a registered output.
module answer_history #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           din,
    input  logic                       store,
    input  logic                       prev,
    input  logic                       next,
    input  logic                       clr,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH)-1:0]   idx,
    output logic                       empty,
    output logic                       full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic             store_q, prev_q, next_q;
    logic             rise_store, rise_prev, rise_next;
    logic [IW-1:0]    wp;
    logic [IW-1:0]    prev_addr, next_addr;
    logic             can_prev, can_next;
    logic [WIDTH-1:0] mem [DEPTH];

    assign rise_store = store & ~store_q;
    assign rise_prev  = prev  & ~prev_q;
    assign rise_next  = next  & ~next_q;

    // Pointer arithmetic wraps naturally because the address width is log2(DEPTH).
    assign prev_addr = wp - IW'(2) - idx;
    assign next_addr = wp - idx;
    assign can_prev  = (CW'(idx) + CW'(1)) < count;
    assign can_next  = idx != '0;

    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);

    // NOTE: the history array carries no reset; count and idx alone decide
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (reset && !clr && rise_store) begin
            mem[wp] <= din;
        end
    end

    // NOTE: every sequential assignment is non-blocking so all state in this
    // block updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            store_q <= 1'b1;
            prev_q  <= 1'b1;
            next_q  <= 1'b1;
            wp      <= '0;
            idx     <= '0;
            count   <= '0;
            out     <= '0;
        end else begin
            store_q <= store;
            prev_q  <= prev;
            next_q  <= next;
            if (clr) begin
                wp    <= '0;
                idx   <= '0;
                count <= '0;
                out   <= '0;
            end else if (rise_store) begin
                wp    <= wp + IW'(1);
                idx   <= '0;
                out   <= din;
                count <= full ? count : count + CW'(1);
            end else if (rise_prev && !rise_next) begin
                if (can_prev) begin
                    idx <= idx + IW'(1);
                    out <= mem[prev_addr];
                end
            end else if (rise_next && !rise_prev) begin
                if (can_next) begin
                    idx <= idx - IW'(1);
                    out <= mem[next_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_answer_history.sv
// Randomised and directed bench for answer_history, scored against a
// newest-first queue model of the history.
module tb_answer_history;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             store, prev, next, clr;
    logic [WIDTH-1:0] out;
    logic [2:0]       count;
    logic [1:0]       idx;
    logic             empty, full;

    answer_history #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .store (store),
        .prev  (prev),
        .next  (next),
        .clr   (clr),
        .out   (out),
        .count (count),
        .idx   (idx),
        .empty (empty),
        .full  (full)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: hist[0] is the newest answer, m_idx is the age being shown.
    logic [WIDTH-1:0] hist[$];
    int               m_idx = 0;
    bit               l_store = 1'b1, l_prev = 1'b1, l_next = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit rs, rp, rn;
        if (!reset) begin
            hist.delete();
            m_idx   = 0;
            l_store = 1'b1;
            l_prev  = 1'b1;
            l_next  = 1'b1;
            return;
        end
        rs = store && !l_store;
        rp = prev && !l_prev;
        rn = next && !l_next;
        l_store = store;
        l_prev  = prev;
        l_next  = next;
        if (clr) begin
            hist.delete();
            m_idx = 0;
        end else if (rs) begin
            hist.push_front(din);
            if (hist.size() > DEPTH) void'(hist.pop_back());
            m_idx = 0;
        end else if (rp && !rn) begin
            if (m_idx + 1 < hist.size()) m_idx++;
        end else if (rn && !rp) begin
            if (m_idx > 0) m_idx--;
        end
    endtask

    task automatic tick();
        logic [WIDTH-1:0] exp_out;
        @(posedge clk);
        model_edge();
        #1;
        exp_out = (hist.size() == 0) ? '0 : hist[m_idx];
        check("out",   32'(out),   32'(exp_out));
        check("count", 32'(count), 32'(hist.size()));
        check("idx",   32'(idx),   32'(m_idx));
        check("empty", 32'(empty), 32'(hist.size() == 0));
        check("full",  32'(full),  32'(hist.size() == DEPTH));
    endtask

    // One-cycle assertion of the given controls followed by a release cycle.
    task automatic press(input bit s, input bit p, input bit n, input bit c, input logic [WIDTH-1:0] d);
        store = s; prev = p; next = n; clr = c; din = d;
        tick();
        store = 0; prev = 0; next = 0; clr = 0;
        tick();
    endtask

    initial begin
        reset = 0; store = 1; prev = 0; next = 0; clr = 0; din = 8'hA5;
        repeat (2) tick();
        check("rst_out", 32'(out), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        // store held through reset release must not capture
        reset = 1;
        repeat (3) tick();
        check("held_store_count", 32'(count), 32'h0);
        store = 0;
        tick();

        // store held for five cycles: a single capture
        din = 8'h11; store = 1;
        repeat (5) tick();
        store = 0;
        tick();
        check("hold_count", 32'(count), 32'h1);
        press(1, 0, 0, 0, 8'h22);
        press(1, 0, 0, 0, 8'h33);
        check("s3_out", 32'(out), 32'h33);
        check("s3_count", 32'(count), 32'h3);

        press(0, 1, 0, 0, 8'h00); check("p1_out", 32'(out), 32'h22);
        press(0, 1, 0, 0, 8'h00); check("p2_out", 32'(out), 32'h11);
        press(0, 1, 0, 0, 8'h00); check("p3_sat", 32'(idx), 32'h2);
        press(0, 0, 1, 0, 8'h00); check("n1_out", 32'(out), 32'h22);
        press(0, 0, 1, 0, 8'h00);
        press(0, 0, 1, 0, 8'h00); check("n3_out", 32'(out), 32'h33);

        press(1, 0, 0, 0, 8'h44);
        press(1, 0, 0, 0, 8'h55);
        check("full_flag", 32'(full), 32'h1);
        repeat (3) press(0, 1, 0, 0, 8'h00);
        check("wrap_p3", 32'(out), 32'h22);
        press(0, 1, 0, 0, 8'h00);
        check("wrap_p4", 32'(out), 32'h22);

        press(0, 1, 1, 0, 8'h00);          // prev+next together: nothing
        press(1, 1, 0, 0, 8'h66);          // store wins over prev
        check("store_prev_out", 32'(out), 32'h66);
        check("store_prev_idx", 32'(idx), 32'h0);

        repeat (2) press(0, 1, 0, 0, 8'h00);
        check("pre_rst_idx", 32'(idx), 32'h2);
        reset = 0;
        tick();
        reset = 1;
        tick();
        press(1, 0, 0, 0, 8'h77);
        check("post_rst_count", 32'(count), 32'h1);
        check("post_rst_out", 32'(out), 32'h77);

        press(1, 0, 0, 1, 8'h88);          // clr beats store
        check("clr_store_count", 32'(count), 32'h0);

        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(99) != 0);
            store = ($urandom_range(3) == 0);
            prev  = ($urandom_range(2) == 0);
            next  = ($urandom_range(2) == 0);
            clr   = ($urandom_range(29) == 0);
            din   = WIDTH'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
